// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: button-driven mode/speed controller for a 12-LED bounce, fill or blink pattern
module led_pattern_ctrl #(
  parameter int TICK_BASE = 1000000,
  parameter int CNT_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_speed,
  input  logic        pause,
  output logic [11:0] led,
  output logic [1:0]  mode,
  output logic [1:0]  speed,
  output logic        step
);
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] BLINK = 2'd2;
  logic [11:0] led_q, led_d, seed, stepped, bounce_led;
  logic [1:0] mode_q, mode_d, mode_nx, speed_q, speed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, p_last;
  logic dir_q, dir_d, step_q, step_d, btn_mode_q, btn_speed_q, boot_q;
  logic mode_rise, speed_rise, btn, tick, bounce_dir, is_bounce;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q <= 12'h060;
      mode_q <= 2'd0;
      speed_q <= 2'd0;
      dir_q <= 1'b0;
      cnt_q <= '0;
      step_q <= 1'b0;
      btn_mode_q <= 1'b0;
      btn_speed_q <= 1'b0;
      boot_q <= 1'b1;
    end else begin
      led_q <= led_d;
      mode_q <= mode_d;
      speed_q <= speed_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      btn_mode_q <= btn_mode;
      btn_speed_q <= btn_speed;
      boot_q <= 1'b0;
    end
  end
  // boot_q masks the first post-reset cycle so a button held through reset is not seen as a press
  always_comb begin
    mode_rise = btn_mode & ~btn_mode_q & ~boot_q;
    speed_rise = btn_speed & ~btn_speed_q & ~boot_q;
    btn = mode_rise | speed_rise;
    p_last = CNT_W'((TICK_BASE >> speed_q) - 1);
    tick = ~pause & ~btn & (cnt_q == p_last);
    cnt_d = (btn || tick) ? '0 : pause ? cnt_q : cnt_q + 1'b1;
    mode_nx = mode_q[1] ? 2'd0 : mode_q + 2'd1;
    mode_d = mode_rise ? mode_nx : mode_q;
    speed_d = speed_rise ? speed_q + 2'd1 : speed_q;
    seed = mode_nx == FILL ? 12'h000 : mode_nx == BLINK ? 12'hAAA : 12'h060;
    is_bounce = mode_q != FILL && mode_q != BLINK;
    bounce_led = dir_q ? (led_q[0] ? led_q << 1 : led_q >> 1) : (led_q[11] ? led_q >> 1 : led_q << 1);
    bounce_dir = dir_q ? ~led_q[0] : led_q[11];
    stepped = mode_q == FILL ? (&led_q ? 12'h000 : {led_q[10:0], 1'b1}) : mode_q == BLINK ? ~led_q : bounce_led;
    led_d = mode_rise ? seed : tick ? stepped : led_q;
    dir_d = mode_rise ? 1'b0 : (tick && is_bounce) ? bounce_dir : dir_q;
    step_d = tick;
  end
  always_comb begin
    led = led_q;
    mode = mode_q;
    speed = speed_q;
    step = step_q;
  end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: table vectors, corner sequences and random run against a phase-index reference model
module tb_led_pattern_ctrl;
  logic clk = 0, rst_n = 0, btn_mode = 0, btn_speed = 0, pause = 0;
  logic [11:0] led;
  logic [1:0] mode, speed;
  logic step;
  int total = 0, bad = 0;
  led_pattern_ctrl #(.TICK_BASE(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_speed(btn_speed), .pause(pause),
    .led(led), .mode(mode), .speed(speed), .step(step)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit rst_n, bm, bs, pz;
    int n;
    logic [11:0] led;
    logic [1:0] mode, speed;
    bit step;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: pattern is a phase index per mode, timing is elapsed cycles against the period
  int m_mode = 0, m_speed = 0, m_idx = 5, m_el = 0;
  bit m_step = 0, pm = 1, ps = 1, rm, rs;
  function automatic logic [11:0] m_led(int md, int idx);
    int ph, b;
    if (md == 1) return 12'((1 << (idx % 13)) - 1);
    if (md == 2) return (idx % 2) ? 12'h555 : 12'hAAA;
    ph = idx % 20;
    b = ph <= 10 ? ph : 20 - ph;
    return 12'(3 << b);
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_speed = 0; m_idx = 5; m_el = 0; m_step = 0; pm = 1; ps = 1;
    end else begin
      rm = btn_mode && !pm;
      rs = btn_speed && !ps;
      pm = btn_mode;
      ps = btn_speed;
      m_step = 0;
      if (rm || rs) begin
        if (rm) begin
          m_mode = m_mode >= 2 ? 0 : m_mode + 1;
          m_idx = m_mode == 0 ? 5 : 0;
        end
        if (rs) m_speed = (m_speed + 1) % 4;
        m_el = 0;
      end else if (!pause) begin
        m_el++;
        if (m_el == (8 >> m_speed)) begin
          m_el = 0;
          m_idx++;
          m_step = 1;
        end
      end
    end
  end
  bit mchk = 1;
  always @(negedge clk) if (mchk) begin
    chk("model_led", 32'(led), 32'(m_led(m_mode, m_idx)));
    chk("model_mode", 32'(mode), 32'(m_mode));
    chk("model_speed", 32'(speed), 32'(m_speed));
    chk("model_step", 32'(step), 32'(m_step));
  end
  initial begin
    int gap;
    vecs.push_back('{0, 0, 0, 0, 2, 12'h060, 2'd0, 2'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 7, 12'h060, 2'd0, 2'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 12'h0C0, 2'd0, 2'd0, 1});
    vecs.push_back('{1, 0, 0, 0, 1, 12'h0C0, 2'd0, 2'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 7, 12'h180, 2'd0, 2'd0, 1});
    vecs.push_back('{1, 0, 0, 0, 32, 12'h600, 2'd0, 2'd0, 1});
    vecs.push_back('{1, 1, 0, 0, 1, 12'h000, 2'd1, 2'd0, 0});
    vecs.push_back('{1, 1, 0, 0, 19, 12'h003, 2'd1, 2'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 5, 12'h007, 2'd1, 2'd0, 1});
    vecs.push_back('{1, 0, 0, 0, 80, 12'h000, 2'd1, 2'd0, 1});
    vecs.push_back('{1, 1, 0, 0, 1, 12'hAAA, 2'd2, 2'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 8, 12'h555, 2'd2, 2'd0, 1});
    vecs.push_back('{1, 0, 1, 0, 1, 12'h555, 2'd2, 2'd1, 0});
    vecs.push_back('{1, 0, 0, 0, 4, 12'hAAA, 2'd2, 2'd1, 1});
    vecs.push_back('{1, 0, 1, 0, 1, 12'hAAA, 2'd2, 2'd2, 0});
    vecs.push_back('{1, 0, 0, 0, 2, 12'h555, 2'd2, 2'd2, 1});
    vecs.push_back('{1, 0, 1, 0, 1, 12'h555, 2'd2, 2'd3, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 12'hAAA, 2'd2, 2'd3, 1});
    vecs.push_back('{1, 0, 0, 0, 1, 12'h555, 2'd2, 2'd3, 1});
    vecs.push_back('{0, 1, 0, 0, 1, 12'h060, 2'd0, 2'd0, 0});
    vecs.push_back('{1, 1, 0, 0, 3, 12'h060, 2'd0, 2'd0, 0});
    vecs.push_back('{1, 0, 0, 0, 1, 12'h060, 2'd0, 2'd0, 0});
    vecs.push_back('{1, 1, 0, 0, 1, 12'h000, 2'd1, 2'd0, 0});
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; btn_mode = vecs[i].bm; btn_speed = vecs[i].bs; pause = vecs[i].pz;
      repeat (vecs[i].n) @(negedge clk);
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
      chk($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
      chk($sformatf("vec%0d_speed", i), 32'(speed), 32'(vecs[i].speed));
      chk($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].step));
    end
    rst_n = 0; btn_mode = 0; btn_speed = 0; pause = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    pause = 1;
    repeat (50) begin
      @(negedge clk);
      chk("pause_led", 32'(led), 32'h060);
      chk("pause_step", 32'(step), 32'h0);
    end
    pause = 0;
    repeat (4) @(negedge clk);
    chk("unpause_hold", 32'(led), 32'h060);
    @(negedge clk);
    chk("unpause_led", 32'(led), 32'h0C0);
    chk("unpause_step", 32'(step), 32'h1);
    repeat (7) @(negedge clk);
    btn_speed = 1;
    @(negedge clk);
    chk("tc_press_speed", 32'(speed), 32'h1);
    chk("tc_press_led", 32'(led), 32'h0C0);
    chk("tc_press_step", 32'(step), 32'h0);
    btn_speed = 0;
    repeat (3) @(negedge clk);
    chk("tc_wait_led", 32'(led), 32'h0C0);
    @(negedge clk);
    chk("tc_next_led", 32'(led), 32'h180);
    chk("tc_next_step", 32'(step), 32'h1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int s = 1; s <= 16; s++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!step && gap < 20);
      chk("bounce_gap", 32'(gap), 32'd8);
      if (s == 15) chk("bounce_end", 32'(led), 32'h003);
      if (s == 16) chk("bounce_turn", 32'(led), 32'h006);
    end
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 15) == 0) btn_speed = ~btn_speed;
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      rst_n = $urandom_range(0, 299) != 0;
      @(negedge clk);
    end
    mchk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Mode and rate controller for the 12-LED display.
- Selects one of three LED patterns: bounce, fill or blink.
- Advances the selected pattern at a programmable step rate derived from clk.
- Takes mode/speed pushbutton inputs and a pause switch.
- Replaces the free-running bounce-plus-divider pairing with one sequenced, user-controllable block.

Parameters:
TICK_BASE, 1000000, clk cycles per pattern step at speed 0. Must be ≥8 and a multiple of 8.
CNT_W, 20, prescaler width. Must satisfy 2^CNT_W > TICK_BASE.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
btn_mode  input  1  mode button; already synchronized and debounced; active high
btn_speed  input  1  speed button; already synchronized and debounced; active high
pause  input  1  level; 1 freezes pattern and prescaler
led  output  12  LED drive; bit 11 leftmost
mode  output  2  current mode: 0 BOUNCE, 1 FILL, 2 BLINK
speed  output  2  current speed index 0..3
step  output  1  one-cycle pulse, high in the cycle after led updated by a step

Behaviour:
- Reset: rst_n low at a rising edge sets led=12'h060, mode=0, speed=0, dir=LEFT, prescaler=0, step=0, btn history regs=0.
- Reset overrides every other event in the same cycle.
- Edge detect: internal registers btn_mode_q and btn_speed_q hold the previous samples. A rise is input=1 with _q=0. A held button produces exactly one event.
- Step period: P = TICK_BASE >> speed, giving TICK_BASE, /2, /4, /8.
- Prescaler:
  - Counts 0..P-1 while pause=0.
  - At count==P-1 it wraps to 0 and a step occurs on that same edge: led updates, and step=1 on the following cycle.
  - pause=1: count and led hold; step stays 0.
- Mode rise:
  - mode advances 0→1→2→0.
  - led loads the new mode's seed.
  - BOUNCE entry sets dir=LEFT.
  - Prescaler clears to 0.
  - No step that cycle.
- Speed rise:
  - speed advances 0→1→2→3→0.
  - Prescaler clears to 0.
  - led and mode are unchanged.
- Simultaneous mode and speed rises: both apply and the prescaler clears.
- Button rise coincident with prescaler terminal count: the button wins; no step occurs and the prescaler clears.
- Button rises are honoured while pause=1. Mode still reloads the seed, and the prescaler clears and stays held.
- BOUNCE (seed 12'h060):
  - dir LEFT: if led[11]=1, set dir=RIGHT and led=led>>1; else led=led<<1.
  - dir RIGHT: if led[0]=1, set dir=LEFT and led=led<<1; else led=led>>1.
  - The turn consumes a step; there is no dead step at the ends.
- FILL (seed 12'h000): if led==12'hFFF, led=12'h000; else led={led[10:0],1'b1}. The cycle length is 13 steps.
- BLINK (seed 12'hAAA): led=~led, alternating 12'hAAA and 12'h555.
- mode value 3 is unreachable. If it is ever observed, treat it as BOUNCE and the next mode rise goes to 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Bounce with TICK_BASE=8, pause=0, release rst_n:
   - First led change is at the 8th rising edge, 0x060→0x0C0, with step=1 the next cycle.
   - Sequence continues 0x180…0xC00, then 0x600 on the next step.
2. Bounce right turn:
   - Sequence 0x00C→0x006→0x003, then 0x006 and dir=LEFT.
   - Exactly 8 cycles between step pulses.
3. Mode press, held 20 cycles:
   - mode=1 and led=0x000 next cycle; only one mode increment occurs.
   - Then 0x001, 0x003 … 0xFFF, and the 13th step gives 0x000.
   - Second press: mode=2, led=0xAAA, then steps alternate 0x555/0xAAA.
4. Speed presses:
   - Step spacing 8 → 4 → 2 → 1 cycles after presses 1–3.
   - 4th press: speed=0, spacing 8.
   - Press at terminal count: no step, and the next step lands P cycles later.
5. Pause:
   - Assert at prescaler count 3 for 50 cycles: led constant, step=0.
   - Deassert: next step occurs after 4 further edges (count 4..7).
6. Reset mid-run:
   - rst_n low for 1 cycle in BLINK at speed 3 → led=0x060, mode=0, speed=0, step=0 next cycle.
   - btn_mode held high across reset: no mode event until it is released and pressed again.
